main_memory: RTL and testbench



---
 rtl/main_memory_pkg.sv | 13 +
 rtl/main_memory_mem_array.sv | 36 +++
 rtl/main_memory.sv | 108 ++++++++++
 tb/tb_main_memory.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/main_memory_pkg.sv
// Shared types and constants for the main-memory responder.
package main_memory_pkg;

  // Responder states: IDLE accepts a request, BUSY models the access latency.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Width of the statistics counters and of the latency down-counter.
  localparam int CNT_W = 32;

endpackage

// File: rtl/main_memory_mem_array.sv
// Single-port synchronous word RAM with a registered read port.
// The array starts at zero and is never touched by reset; only the read register clears.
module main_memory_mem_array #(
  parameter int WORD_WIDTH = 64,
  parameter int SIZE_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [SIZE_BITS-1:0]  idx,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << SIZE_BITS;

  logic [WORD_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // Commit a write at the accept edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wdata;
    end
  end

  // Capture read data at the accept edge; held until the next read or a clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/main_memory.sv
// Terminal memory of a simulated hierarchy: accepts one read or write when
// idle, stays busy for LATENCY cycles, and keeps per-type access counts.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64,
  parameter int SIZE_BITS  = 10,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] dout,
  input  logic                  re,
  input  logic                  we,
  output logic                  ready,
  output logic [CNT_W-1:0]      read_count,
  output logic [CNT_W-1:0]      write_count
);

  // Counter reload value; irrelevant (and kept at zero) when there is no BUSY state.
  localparam logic [CNT_W-1:0] LAT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lat_cnt, lat_cnt_nxt;
  logic             rd_pend, rd_pend_nxt;
  logic             accept;
  logic             acc_rd;
  logic             acc_wr;
  logic             rd_done;

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^addr[ADDR_WIDTH-1:SIZE_BITS];

  // Next-state, accept decode and read-completion detection.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    rd_pend_nxt = rd_pend;
    rd_done     = 1'b0;
    ready       = (state == IDLE) || (LATENCY == 0);
    // Reset on the same edge suppresses any accept.
    accept      = ready && (re || we) && !rst;
    // Read wins over a simultaneous write; the write is dropped entirely.
    acc_rd      = accept && re;
    acc_wr      = accept && we && !re;
    if (LATENCY == 0) begin
      rd_done = acc_rd;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt   = BUSY;
            lat_cnt_nxt = LAT_LOAD;
            rd_pend_nxt = re;
          end
        end
        BUSY: begin
          if (lat_cnt == '0) begin
            state_nxt   = IDLE;
            rd_done     = rd_pend;
            rd_pend_nxt = 1'b0;
          end else begin
            lat_cnt_nxt = lat_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // State, latency counter and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      rd_pend     <= 1'b0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      rd_pend <= rd_pend_nxt;
      if (acc_wr) begin
        write_count <= write_count + 1'b1;
      end
      if (rd_done) begin
        read_count <= read_count + 1'b1;
      end
    end
  end

  main_memory_mem_array #(
    .WORD_WIDTH (WORD_WIDTH),
    .SIZE_BITS  (SIZE_BITS)
  ) u_array (
    .clk   (clk),
    .clr   (rst),
    .wr_en (acc_wr),
    .rd_en (acc_rd),
    .idx   (addr[SIZE_BITS-1:0]),
    .wdata (din),
    .rdata (dout)
  );

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: one instance with LATENCY=4, one with LATENCY=0,
// each checked against its own reference array and a read-data scoreboard.
module tb_main_memory;

  logic        clk = 1'b0;
  logic        rst4, rst0;
  logic [63:0] addr4, din4, dout4, addr0, din0, dout0;
  logic        re4, we4, rdy4, re0, we0, rdy0;
  logic [31:0] rcnt4, wcnt4, rcnt0, wcnt0;

  logic [63:0] mdl4 [1024];
  logic [63:0] mdl0 [1024];
  logic [63:0] sb4 [$];
  logic [63:0] sb0 [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_r4 = 0, exp_w4 = 0, exp_r0 = 0, exp_w0 = 0;

  always #5 clk = ~clk;

  main_memory #(.ADDR_WIDTH(64), .WORD_WIDTH(64), .SIZE_BITS(10), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst4), .addr(addr4), .din(din4), .dout(dout4), .re(re4), .we(we4),
    .ready(rdy4), .read_count(rcnt4), .write_count(wcnt4)
  );

  main_memory #(.ADDR_WIDTH(64), .WORD_WIDTH(64), .SIZE_BITS(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst0), .addr(addr0), .din(din0), .dout(dout0), .re(re0), .we(we0),
    .ready(rdy0), .read_count(rcnt0), .write_count(wcnt0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the LATENCY=4 instance: drive, count busy cycles, then check.
  task automatic op4(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d);
    int busy;
    @(negedge clk);
    re4 = r; we4 = w; addr4 = a; din4 = d;
    if (r) begin
      sb4.push_back(mdl4[a[9:0]]);
      exp_r4++;
    end else if (w) begin
      mdl4[a[9:0]] = d;
      exp_w4++;
    end
    @(posedge clk);
    #1;
    re4 = 1'b0; we4 = 1'b0;
    busy = 0;
    while (busy < 20) begin
      @(negedge clk);
      if (rdy4) break;
      busy++;
    end
    chk("busy_cycles", busy, 4);
    if (r) begin
      if (sb4.size() > 0) chk("l4_rdata", dout4, sb4.pop_front());
      else chk("l4_sb_empty", 0, 1);
    end
    chk("l4_rcnt", rcnt4, exp_r4);
    chk("l4_wcnt", wcnt4, exp_w4);
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
  } op_t;

  initial begin
    op_t ops0 [7];
    for (int i = 0; i < 1024; i++) begin
      mdl4[i] = '0;
      mdl0[i] = '0;
    end
    rst4 = 1'b1; rst0 = 1'b1;
    re4 = 1'b0; we4 = 1'b0; addr4 = '0; din4 = '0;
    re0 = 1'b0; we0 = 1'b0; addr0 = '0; din0 = '0;
    repeat (2) @(negedge clk);
    rst4 = 1'b0; rst0 = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_ready", rdy4, 1);
      chk("rst_dout", dout4, 0);
      chk("rst_rcnt", rcnt4, 0);
      chk("rst_wcnt", wcnt4, 0);
    end

    // Basic write then read back
    op4(1'b0, 1'b1, 64'h5, 64'hDEAD);
    op4(1'b1, 1'b0, 64'h5, 64'h0);
    // Aliasing above 2^SIZE_BITS
    op4(1'b0, 1'b1, 64'h400, 64'h1234);
    op4(1'b1, 1'b0, 64'h0, 64'h0);
    chk("alias_val", dout4, 64'h1234);
    // Read wins over simultaneous write
    op4(1'b0, 1'b1, 64'h7, 64'h11);
    op4(1'b1, 1'b1, 64'h7, 64'h22);
    chk("rw_both_val", dout4, 64'h11);
    op4(1'b1, 1'b0, 64'h7, 64'h0);
    chk("rw_contents", dout4, 64'h11);

    // Reset in the middle of a read, with re held through BUSY
    @(negedge clk);
    re4 = 1'b1; addr4 = 64'h5;
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", rdy4, 0);
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    rst4 = 1'b0; re4 = 1'b0;
    exp_r4 = 0; exp_w4 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstb_ready", rdy4, 1);
      chk("rstb_dout", dout4, 0);
      chk("rstb_rcnt", rcnt4, 0);
      chk("rstb_wcnt", wcnt4, 0);
    end
    // Committed write survives the reset
    op4(1'b1, 1'b0, 64'h5, 64'h0);
    chk("post_rst_val", dout4, 64'hDEAD);

    // Zero-latency instance: back-to-back writes and reads
    ops0[0] = '{1'b0, 1'b1, 64'h1, 64'hA1};
    ops0[1] = '{1'b0, 1'b1, 64'h2, 64'hB2};
    ops0[2] = '{1'b0, 1'b1, 64'h3, 64'hC3};
    ops0[3] = '{1'b1, 1'b0, 64'h1, 64'h0};
    ops0[4] = '{1'b1, 1'b0, 64'h2, 64'h0};
    ops0[5] = '{1'b1, 1'b0, 64'h3, 64'h0};
    ops0[6] = '{1'b0, 1'b0, 64'h0, 64'h0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("l0_ready", rdy0, 1);
      if (sb0.size() > 0) chk("l0_rdata", dout0, sb0.pop_front());
      chk("l0_rcnt", rcnt0, exp_r0);
      chk("l0_wcnt", wcnt0, exp_w0);
      re0 = ops0[i].r; we0 = ops0[i].w; addr0 = ops0[i].a; din0 = ops0[i].d;
      if (ops0[i].r) begin
        sb0.push_back(mdl0[ops0[i].a[9:0]]);
        exp_r0++;
      end else if (ops0[i].w) begin
        mdl0[ops0[i].a[9:0]] = ops0[i].d;
        exp_w0++;
      end
    end
    @(negedge clk);
    chk("l0_rcnt_final", rcnt0, 3);
    chk("l0_wcnt_final", wcnt0, 3);
    chk("l0_last_dout", dout0, 64'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
